// File: rtl/stack_alu_pkg.sv
// Shared opcodes and sequencer state encoding for the stack_alu command path.
package stack_alu_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } seq_state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return (op == OP_NOP) || (op == OP_ADD) || (op == OP_MUL) ||
           (op == OP_PUSH) || (op == OP_POP);
  endfunction

endpackage

// File: rtl/stack_depth_mirror.sv
// Shadow copy of the attached stack_alu element count, updated when an op issues.
module stack_depth_mirror
  import stack_alu_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int DW    = $clog2(DEPTH+1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          upd_i,
  input  logic [2:0]    op_i,
  output logic [DW-1:0] depth_o,
  output logic          can_push_o,
  output logic          can_pop_o,
  output logic          can_binop_o
);

  logic [DW-1:0] depth_q, depth_d;

  // Binary ops pop two and push one, so they shrink the stack by one like POP.
  always_comb begin
    depth_d = depth_q;
    if (upd_i) begin
      case (op_i)
        OP_PUSH:                depth_d = depth_q + DW'(1);
        OP_POP, OP_ADD, OP_MUL: depth_d = depth_q - DW'(1);
        default:                depth_d = depth_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) depth_q <= '0;
    else         depth_q <= depth_d;
  end

  assign depth_o     = depth_q;
  assign can_push_o  = (depth_q != DW'(DEPTH));
  assign can_pop_o   = (depth_q != '0);
  assign can_binop_o = (depth_q >= DW'(2));

endmodule

// File: rtl/stack_alu_sequencer.sv
// Issues RPN commands to stack_alu one at a time and returns results on a response stream.
// Optional perf counters (op_count, ovf_count) are built when STACK_ALU_SEQ_PERF_EN is defined.
// cmd and rsp are valid/ready streams: a beat transfers on a clock edge where valid && ready;
// a producer holds valid and payload stable until that edge.
module stack_alu_sequencer
  import stack_alu_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = 1024,
  parameter int DW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_opcode,
  input  logic [N-1:0]  cmd_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [N-1:0]  rsp_data,
  output logic          rsp_overflow,
  output logic          rsp_error,
  output logic [2:0]    alu_opcode,
  output logic [N-1:0]  alu_data,
  input  logic [N-1:0]  alu_result,
  input  logic          alu_overflow,
  output logic [DW-1:0] depth,
`ifdef STACK_ALU_SEQ_PERF_EN
  output logic [31:0]   op_count,
  output logic [31:0]   ovf_count,
`endif
  output seq_state_e    dbg_state
);

  seq_state_e    state_q, state_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [N-1:0]  rsp_data_q, rsp_data_d;
  logic          rsp_ovf_q, rsp_ovf_d;
  logic          rsp_err_q, rsp_err_d;
  logic [2:0]    alu_op_q, alu_op_d;
  logic [N-1:0]  alu_data_q, alu_data_d;

  logic          accept, reject, issue_upd;
  logic          can_push, can_pop, can_binop;

  assign accept    = (state_q == ST_IDLE) && cmd_valid && cmd_ready_q;
  assign issue_upd = (state_q == ST_ISSUE);

  always_comb begin
    reject = !op_legal(cmd_opcode);
    case (cmd_opcode)
      OP_PUSH:        reject = !can_push;
      OP_POP:         reject = !can_pop;
      OP_ADD, OP_MUL: reject = !can_binop;
      default:        ;
    endcase
  end

  stack_depth_mirror #(.DEPTH(DEPTH), .DW(DW)) u_depth (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .upd_i       (issue_upd),
    .op_i        (alu_op_q),
    .depth_o     (depth),
    .can_push_o  (can_push),
    .can_pop_o   (can_pop),
    .can_binop_o (can_binop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && cmd_opcode != OP_NOP) state_d = reject ? ST_RESP : ST_ISSUE;
      end
      ST_ISSUE: state_d = (alu_op_q == OP_PUSH) ? ST_IDLE : ST_WAIT;
      ST_WAIT:  state_d = ST_RESP;
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Payloads hold by default so a stalled response stays stable.
  always_comb begin
    rsp_data_d  = rsp_data_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_err_d   = rsp_err_q;
    alu_op_d    = alu_op_q;
    alu_data_d  = alu_data_q;
    cmd_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    case (state_q)
      ST_IDLE: begin
        if (accept && cmd_opcode != OP_NOP) begin
          if (reject) begin
            rsp_data_d = '0;
            rsp_ovf_d  = 1'b0;
            rsp_err_d  = 1'b1;
          end else begin
            alu_op_d   = cmd_opcode;
            alu_data_d = (cmd_opcode == OP_PUSH) ? cmd_data : '0;
          end
        end
      end
      ST_ISSUE: begin
        alu_op_d   = OP_NOP;
        alu_data_d = '0;
      end
      ST_WAIT: begin
        rsp_data_d = alu_result;
        rsp_ovf_d  = alu_overflow;
        rsp_err_d  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      alu_op_q    <= OP_NOP;
      alu_data_q  <= '0;
    end else begin
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_err_q   <= rsp_err_d;
      alu_op_q    <= alu_op_d;
      alu_data_q  <= alu_data_d;
    end
  end

`ifdef STACK_ALU_SEQ_PERF_EN
  logic [31:0] op_count_q, ovf_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q  <= '0;
      ovf_count_q <= '0;
    end else begin
      if (issue_upd && op_count_q != '1) op_count_q <= op_count_q + 32'd1;
      if (state_q == ST_WAIT && alu_overflow && ovf_count_q != '1)
        ovf_count_q <= ovf_count_q + 32'd1;
    end
  end

  assign op_count  = op_count_q;
  assign ovf_count = ovf_count_q;
`endif

  assign cmd_ready    = cmd_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_overflow = rsp_ovf_q;
  assign rsp_error    = rsp_err_q;
  assign alu_opcode   = alu_op_q;
  assign alu_data     = alu_data_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// Directed bench for stack_alu_sequencer with a small behavioural stack_alu attached (N=4, DEPTH=4).
module tb_stack_alu_sequencer;
  import stack_alu_pkg::*;

  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int DW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_opcode = 3'b000;
  logic [N-1:0]  cmd_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [N-1:0]  rsp_data;
  logic          rsp_overflow;
  logic          rsp_error;
  logic [2:0]    alu_opcode;
  logic [N-1:0]  alu_data;
  logic [N-1:0]  alu_result;
  logic          alu_overflow;
  logic [DW-1:0] depth;
  seq_state_e    dbg_state;
`ifdef STACK_ALU_SEQ_PERF_EN
  logic [31:0]   op_count, ovf_count;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stack_alu_sequencer #(.N(N), .DEPTH(DEPTH), .DW(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_opcode   (cmd_opcode),
    .cmd_data     (cmd_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_overflow (rsp_overflow),
    .rsp_error    (rsp_error),
    .alu_opcode   (alu_opcode),
    .alu_data     (alu_data),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .depth        (depth),
`ifdef STACK_ALU_SEQ_PERF_EN
    .op_count     (op_count),
    .ovf_count    (ovf_count),
`endif
    .dbg_state    (dbg_state)
  );

  // Behavioural stack_alu: executes the presented opcode on the clock edge, registered result.
  logic signed [N-1:0] mstk[$];
  always @(posedge clk or negedge rst_n) begin
    logic signed [N-1:0] a, b, r;
    int s, rv;
    if (!rst_n) begin
      mstk.delete();
      alu_result   <= '0;
      alu_overflow <= 1'b0;
    end else begin
      case (alu_opcode)
        OP_PUSH: mstk.push_back(alu_data);
        OP_POP: begin
          r = (mstk.size() > 0) ? mstk.pop_back() : '0;
          alu_result   <= r;
          alu_overflow <= 1'b0;
        end
        OP_ADD, OP_MUL: begin
          b = (mstk.size() > 0) ? mstk.pop_back() : '0;
          a = (mstk.size() > 0) ? mstk.pop_back() : '0;
          s = (alu_opcode == OP_ADD) ? (int'(a) + int'(b)) : (int'(a) * int'(b));
          r = s[N-1:0];
          rv = r;
          mstk.push_back(r);
          alu_result   <= r;
          alu_overflow <= (rv != s);
        end
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [N-1:0] d);
    int n = 0;
    while (!cmd_ready && n < 20) begin step(); n++; end
    check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_data   = d;
    step();
    cmd_valid  = 1'b0;
    cmd_opcode = OP_NOP;
    cmd_data   = '0;
  endtask

  task automatic expect_rsp(input string tag, input logic [N-1:0] d, input logic ovf, input logic err);
    int n = 0;
    while (!rsp_valid && n < 20) begin step(); n++; end
    check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, "_data"},  32'(rsp_data), 32'(d));
    check({tag, "_ovf"},   {31'd0, rsp_overflow}, {31'd0, ovf});
    check({tag, "_err"},   {31'd0, rsp_error}, {31'd0, err});
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check({tag, "_released"}, {30'd0, rsp_valid, cmd_ready}, 32'b01);
  endtask

  initial begin
    #12;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_flags", {30'd0, rsp_overflow, rsp_error}, 32'd0);
    check("rst_alu", {25'd0, alu_opcode, alu_data}, 32'd0);
    check("rst_depth", 32'(depth), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // POP on empty stack is rejected on the accept edge without touching the ALU
    send(OP_POP, '0);
    check("pop_empty_latency", {30'd0, rsp_valid, rsp_error}, 32'b11);
    check("pop_empty_alu_op", 32'(alu_opcode), 32'(OP_NOP));
    expect_rsp("pop_empty", 4'h0, 1'b0, 1'b1);
    check("pop_empty_depth", 32'(depth), 32'd0);

    send(OP_PUSH, 4'h3);
    check("push_issue_op", 32'(alu_opcode), 32'(OP_PUSH));
    check("push_issue_data", 32'(alu_data), 32'h3);
    check("push_issue_ready", {31'd0, cmd_ready}, 32'd0);
    step();
    check("push_done", {27'd0, cmd_ready, alu_opcode, rsp_valid}, {27'd0, 1'b1, 3'b000, 1'b0});
    check("push_depth", 32'(depth), 32'd1);

    send(OP_ADD, '0);
    expect_rsp("add_short", 4'h0, 1'b0, 1'b1);
    check("add_short_depth", 32'(depth), 32'd1);

    send(OP_PUSH, 4'hB);
    step();
    check("push2_depth", 32'(depth), 32'd2);
    send(OP_ADD, '0);
    check("add_issue_op", 32'(alu_opcode), 32'(OP_ADD));
    step();
    check("add_wait", {31'd0, rsp_valid}, 32'd0);
    check("add_wait_depth", 32'(depth), 32'd1);
    step();
    check("add_latency", {31'd0, rsp_valid}, 32'd1);
    expect_rsp("add", 4'hE, 1'b0, 1'b0);

    send(OP_PUSH, 4'h7);
    step();
    send(OP_PUSH, 4'h6);
    step();
    send(OP_MUL, '0);
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      check("mul_hold", {26'd0, rsp_valid, rsp_overflow, rsp_data}, {26'd0, 1'b1, 1'b1, 4'hA});
      step();
    end
    expect_rsp("mul", 4'hA, 1'b1, 1'b0);
    check("mul_depth", 32'(depth), 32'd2);

    send(OP_PUSH, 4'h1);
    step();
    send(OP_PUSH, 4'h2);
    step();
    check("full_depth", 32'(depth), 32'd4);
    send(OP_PUSH, 4'h5);
    expect_rsp("push_full", 4'h0, 1'b0, 1'b1);
    check("push_full_depth", 32'(depth), 32'd4);

    send(OP_POP, '0);
    expect_rsp("pop1", 4'h2, 1'b0, 1'b0);
    send(OP_POP, '0);
    expect_rsp("pop2", 4'h1, 1'b0, 1'b0);
    send(OP_POP, '0);
    expect_rsp("pop3", 4'hA, 1'b0, 1'b0);
    send(OP_POP, '0);
    expect_rsp("pop4", 4'hE, 1'b0, 1'b0);
    check("pop_all_depth", 32'(depth), 32'd0);

    send(3'b010, '0);
    expect_rsp("illegal_010", 4'h0, 1'b0, 1'b1);
    send(3'b001, '0);
    expect_rsp("illegal_001", 4'h0, 1'b0, 1'b1);

    send(OP_NOP, 4'h9);
    check("nop_idle", {29'd0, cmd_ready, rsp_valid, alu_opcode != OP_NOP}, 32'b100);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("nop_no_rsp", {30'd0, cmd_ready, rsp_valid}, 32'b10);
    check("nop_state", 32'(dbg_state), 32'(ST_IDLE));

    send(OP_PUSH, 4'h1);
    step();
    send(OP_PUSH, 4'h2);
    step();
    send(OP_ADD, '0);
    step();
    check("mid_state_wait", 32'(dbg_state), 32'(ST_WAIT));
`ifdef STACK_ALU_SEQ_PERF_EN
    check("perf_op_count", op_count, 32'd15);
    check("perf_ovf_count", ovf_count, 32'd1);
`endif
    rst_n = 1'b0;
    #1;
    check("mid_rst_outputs", {28'd0, rsp_valid, alu_opcode}, 32'd0);
    check("mid_rst_depth", 32'(depth), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
`ifdef STACK_ALU_SEQ_PERF_EN
    check("mid_rst_op_count", op_count, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_ready", {30'd0, cmd_ready, rsp_valid}, 32'b10);
    send(OP_PUSH, 4'h4);
    step();
    send(OP_POP, '0);
    expect_rsp("post_rst_pop", 4'h4, 1'b0, 1'b0);
    check("post_rst_depth", 32'(depth), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
